// File: rtl/err_channel_burst.sv
// err_channel_burst
//   Channel model placed between a convolutional encoder and a Viterbi
//   decoder. Each accepted W-bit symbol is XORed with an error mask that is
//   zero (CLEAN), a pseudo-random isolated hit (RANDOM), a variable-length
//   burst of random masks (BURST) or a caller-supplied mask (FORCED).
//   The output is registered with a fixed latency of one cycle.
//
// Ports
//   clk           clock
//   rst           asynchronous active-low reset
//   valid_i       input symbol strobe
//   data_i        encoder symbol (W bits)
//   mode_i        0 CLEAN, 1 RANDOM, 2 BURST, 3 FORCED
//   force_mask_i  XOR mask used in FORCED mode
//   clear_i       synchronous statistics clear
//   valid_o       registered valid_i
//   data_o        data_i ^ applied mask, registered (holds when idle)
//   err_mask_o    mask applied to the symbol on data_o
//   burst_o       high while the burst FSM is in BURST
//   bit_err_ct_o  saturating count of flipped bits
//   sym_ct_o      saturating count of accepted symbols
//
// Build option
//   ERRCH_STATS_EN  defined: statistics counters present.
//                   undefined: counters tied to 0, clear_i ignored.

module err_channel_burst #(
  parameter int          W     = 2,
  parameter int          N     = 6,
  parameter int          BL_W  = 3,
  parameter logic [31:0] SEED  = 32'hACE1_2024,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [W-1:0]     data_i,
  input  logic [1:0]       mode_i,
  input  logic [W-1:0]     force_mask_i,
  input  logic             clear_i,
  output logic             valid_o,
  output logic [W-1:0]     data_o,
  output logic [W-1:0]     err_mask_o,
  output logic             burst_o,
  output logic [CNT_W-1:0] bit_err_ct_o,
  output logic [CNT_W-1:0] sym_ct_o
);

  localparam logic [31:0] TAPS    = 32'h8020_0003;
  // An all-zero seed would lock the LFSR up, so it is promoted to 1.
  localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [BL_W-1:0] rem_q, rem_d;
  logic [31:0]     lfsr_q, lfsr_d;
  logic [W-1:0]    mask_d;
  logic [W-1:0]    data_q, mask_q;
  logic            valid_q;

  logic            hit;
  logic [W-1:0]    rnd;
  logic [BL_W-1:0] fld;

  // All decisions use the LFSR value before this symbol's advance.
  assign hit = &lfsr_q[N-1:0];
  assign rnd = lfsr_q[31 -: W];
  assign fld = lfsr_q[8 +: BL_W];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    lfsr_d  = lfsr_q;
    mask_d  = '0;
    if (valid_i) begin
      lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'd0);
      // Any non-BURST mode drops an ongoing burst on this very symbol.
      state_d = S_IDLE;
      rem_d   = '0;
      case (mode_i)
        2'd1: begin
          if (hit) mask_d = rnd;
        end
        2'd2: begin
          if (state_q == S_BURST) begin
            // Burst continues regardless of hit; rem_q is always >= 1 here.
            mask_d  = rnd;
            rem_d   = rem_q - BL_W'(1);
            state_d = (rem_q == BL_W'(1)) ? S_IDLE : S_BURST;
          end else if (hit) begin
            // The hitting symbol is the first of 1 + fld corrupted symbols.
            mask_d  = rnd;
            rem_d   = fld;
            state_d = (fld != '0) ? S_BURST : S_IDLE;
          end
        end
        2'd3: begin
          mask_d = force_mask_i;
        end
        default: begin
          mask_d = '0;
        end
      endcase
    end
  end

  // ---- stage boundary: symbol accepted -> registered output ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q  <= SEED_NZ;
      state_q <= S_IDLE;
      rem_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i ^ mask_d;
        mask_q <= mask_d;
      end
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign err_mask_o = mask_q;
  assign burst_o    = (state_q == S_BURST);

`ifdef ERRCH_STATS_EN
  logic [CNT_W-1:0] bit_ct_q, bit_ct_d;
  logic [CNT_W-1:0] sym_ct_q, sym_ct_d;

  function automatic logic [4:0] popcnt(input logic [W-1:0] m);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + 5'(m[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [4:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    bit_ct_d = bit_ct_q;
    sym_ct_d = sym_ct_q;
    if (clear_i) begin
      bit_ct_d = '0;
      sym_ct_d = '0;
    end else if (valid_i) begin
      bit_ct_d = sat_add(bit_ct_q, popcnt(mask_d));
      sym_ct_d = sat_add(sym_ct_q, 5'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_ct_q <= '0;
      sym_ct_q <= '0;
    end else begin
      bit_ct_q <= bit_ct_d;
      sym_ct_q <= sym_ct_d;
    end
  end

  assign bit_err_ct_o = bit_ct_q;
  assign sym_ct_o     = sym_ct_q;
`else
  logic unused_clear;
  assign unused_clear = clear_i;
  assign bit_err_ct_o = '0;
  assign sym_ct_o     = '0;
`endif

endmodule

// File: tb/tb_err_channel_burst.sv
module tb_err_channel_burst;

  localparam logic [31:0] SEED = 32'hACE1_2024;
  localparam logic [31:0] TAPS = 32'h8020_0003;
`ifdef ERRCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [1:0]  data_i;
  logic [1:0]  mode_i;
  logic [1:0]  force_mask_i;
  logic        clear_i;

  logic        valid_o, burst_o;
  logic [1:0]  data_o, err_mask_o;
  logic [15:0] bit_err_ct_o, sym_ct_o;

  logic        s_valid_o, s_burst_o;
  logic [1:0]  s_data_o, s_err_mask_o;
  logic [3:0]  s_bit_err_ct_o, s_sym_ct_o;

  always #5 clk = ~clk;

  err_channel_burst #(.W(2), .N(6), .BL_W(3), .SEED(SEED), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .mode_i(mode_i),
    .force_mask_i(force_mask_i), .clear_i(clear_i), .valid_o(valid_o),
    .data_o(data_o), .err_mask_o(err_mask_o), .burst_o(burst_o),
    .bit_err_ct_o(bit_err_ct_o), .sym_ct_o(sym_ct_o));

  err_channel_burst #(.W(2), .N(6), .BL_W(3), .SEED(SEED), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .mode_i(mode_i),
    .force_mask_i(force_mask_i), .clear_i(clear_i), .valid_o(s_valid_o),
    .data_o(s_data_o), .err_mask_o(s_err_mask_o), .burst_o(s_burst_o),
    .bit_err_ct_o(s_bit_err_ct_o), .sym_ct_o(s_sym_ct_o));

  int checks = 0;
  int errors = 0;

  // Reference channel state
  logic [31:0] m_lfsr;
  bit          m_inburst;
  int          m_left;
  logic [1:0]  m_data, m_mask;
  bit          m_vld;
  int          m_sym, m_bit, s_sym, s_bit;
  int          hits, m_nz, dut_nz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ TAPS;
    return y;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_inburst = 0; m_left = 0;
    m_data = 2'b00; m_mask = 2'b00; m_vld = 0;
    m_sym = 0; m_bit = 0; s_sym = 0; s_bit = 0;
  endtask

  // One clock: drive inputs, advance the reference, compare after the edge.
  task automatic step(input bit v, input logic [1:0] d, input logic [1:0] md,
                      input logic [1:0] fm, input bit clr);
    logic [1:0] mk;
    logic [1:0] rnd;
    bit         hit;
    int         len, pc;
    valid_i = v; data_i = d; mode_i = md; force_mask_i = fm; clear_i = clr;
    mk  = 2'b00;
    hit = (m_lfsr[5:0] == 6'h3F);
    rnd = m_lfsr[31:30];
    len = int'(m_lfsr[10:8]);
    if (v) begin
      if (md != 2'd2) begin
        m_inburst = 0; m_left = 0;
        if (md == 2'd1 && hit) begin mk = rnd; hits++; end
        if (md == 2'd3) mk = fm;
      end else if (m_inburst) begin
        mk = rnd;
        m_left--;
        if (m_left == 0) m_inburst = 0;
      end else if (hit) begin
        mk = rnd;
        m_left = len;
        m_inburst = (len != 0);
      end
      m_lfsr = lfsr_next(m_lfsr);
      m_data = d ^ mk;
      m_mask = mk;
      if (mk != 2'b00) m_nz++;
    end
    m_vld = v;
    pc = int'(mk[0]) + int'(mk[1]);
    if (clr) begin
      m_sym = 0; m_bit = 0; s_sym = 0; s_bit = 0;
    end else if (v) begin
      m_sym = sat(m_sym + 1, 65535);  m_bit = sat(m_bit + pc, 65535);
      s_sym = sat(s_sym + 1, 15);     s_bit = sat(s_bit + pc, 15);
    end
    @(posedge clk);
    #1;
    if (err_mask_o != 2'b00 && valid_o) dut_nz++;
    chk("valid_o", valid_o, m_vld);
    chk("data_o", data_o, m_data);
    chk("err_mask_o", err_mask_o, m_mask);
    chk("burst_o", burst_o, m_inburst);
    chk("sym_ct_o", sym_ct_o, STATS ? m_sym : 0);
    chk("bit_err_ct_o", bit_err_ct_o, STATS ? m_bit : 0);
    chk("sat_data_o", s_data_o, m_data);
    chk("sat_sym_ct_o", s_sym_ct_o, STATS ? s_sym : 0);
    chk("sat_bit_err_ct_o", s_bit_err_ct_o, STATS ? s_bit : 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_mask"}, err_mask_o, 0);
    chk({tag, "_burst"}, burst_o, 0);
    chk({tag, "_bitct"}, bit_err_ct_o, 0);
    chk({tag, "_symct"}, sym_ct_o, 0);
    chk({tag, "_sat_bitct"}, s_bit_err_ct_o, 0);
    chk({tag, "_sat_symct"}, s_sym_ct_o, 0);
  endtask

  initial begin
    bit found;
    int n;
    rst = 1'b0; valid_i = 0; data_i = 0; mode_i = 0; force_mask_i = 0; clear_i = 0;
    hits = 0; m_nz = 0; dut_nz = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk_all_zero("reset");
    rst = 1'b1;

    // CLEAN: 100 symbols of 2'b10
    for (int i = 0; i < 100; i++) begin
      step(1, 2'b10, 2'd0, 2'b00, 0);
      chk("clean_data", data_o, 2'b10);
      chk("clean_mask", err_mask_o, 2'b00);
    end
    chk("clean_symct", sym_ct_o, STATS ? 100 : 0);
    chk("clean_bitct", bit_err_ct_o, 0);

    // FORCED: mask 2'b11 on 2'b01
    for (int i = 0; i < 10; i++) begin
      step(1, 2'b01, 2'd3, 2'b11, 0);
      chk("forced_data", data_o, 2'b10);
    end
    chk("forced_bitct", bit_err_ct_o, STATS ? 20 : 0);
    chk("forced_symct", sym_ct_o, STATS ? 110 : 0);

    // Idle cycle: valid_o drops, data/mask hold
    step(0, 2'b00, 2'd3, 2'b00, 0);
    chk("hold_data", data_o, 2'b10);
    chk("hold_mask", err_mask_o, 2'b11);

    // RANDOM: 4096 symbols against the reference LFSR
    hits = 0; m_nz = 0; dut_nz = 0;
    for (int i = 0; i < 4096; i++) begin
      logic [1:0] dv;
      dv = i[1:0];
      step(1, dv, 2'd1, 2'b00, 0);
    end
    chk("rand_nonzero_masks", dut_nz, m_nz);
    chk("rand_hits_in_range", (hits >= 40 && hits <= 88), 1);

    // BURST: wait for a multi-symbol burst, follow it to its end
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step(1, 2'b00, 2'd2, 2'b00, 0);
      if (m_inburst) found = 1;
    end
    chk("burst_start_seen", found, 1);
    chk("burst_rise", burst_o, 1);
    n = 0;
    for (int i = 0; i < 16 && m_inburst; i++) begin
      step(1, 2'b11, 2'd2, 2'b00, 0);
      n++;
    end
    chk("burst_ended", m_inburst, 0);
    chk("burst_fall", burst_o, 0);

    // Mode switched BURST -> CLEAN mid-burst
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step(1, 2'b01, 2'd2, 2'b00, 0);
      if (m_inburst) found = 1;
    end
    chk("burst2_start_seen", found, 1);
    step(1, 2'b01, 2'd0, 2'b00, 0);
    chk("switch_clean_data", data_o, 2'b01);
    chk("switch_clean_mask", err_mask_o, 2'b00);
    chk("switch_clean_burst", burst_o, 0);

    // Async reset in the middle of a burst
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step(1, 2'b10, 2'd2, 2'b00, 0);
      if (m_inburst) found = 1;
    end
    chk("burst3_start_seen", found, 1);
    #3 rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    valid_i = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 300; i++) step(1, 2'b00, 2'd1, 2'b00, 0);
    for (int i = 0; i < 50; i++) step(1, 2'b01, 2'd2, 2'b00, 0);

    // Saturation on the 4-bit counters and clear behaviour
    step(0, 2'b00, 2'd0, 2'b00, 1);
    chk("clear_idle_sat_sym", s_sym_ct_o, 0);
    for (int i = 0; i < 20; i++) step(1, 2'b01, 2'd3, 2'b11, 0);
    chk("sat_sym_15", s_sym_ct_o, STATS ? 15 : 0);
    chk("sat_bit_15", s_bit_err_ct_o, STATS ? 15 : 0);
    chk("main_sym_20", sym_ct_o, STATS ? 20 : 0);
    chk("main_bit_40", bit_err_ct_o, STATS ? 40 : 0);
    step(1, 2'b01, 2'd3, 2'b11, 1);
    chk("clear_wins_sat_sym", s_sym_ct_o, 0);
    chk("clear_wins_sat_bit", s_bit_err_ct_o, 0);
    chk("clear_wins_sym", sym_ct_o, 0);
    chk("clear_wins_bit", bit_err_ct_o, 0);
    chk("clear_keeps_data", data_o, 2'b10);
    step(1, 2'b00, 2'd3, 2'b01, 0);
    chk("after_clear_sym", sym_ct_o, STATS ? 1 : 0);
    chk("after_clear_bit", bit_err_ct_o, STATS ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
